// File: rtl/fp_mul_pkg.sv
// ----------------------------------------------------------------------------
// fp_mul_pkg
//   Shared constants, types and the Booth partial-product helper for the
//   sequential radix-4 significand multiplier (fp_mul_booth_seq).
//
//   MW     significand width including the hidden bit
//   ITER   number of radix-4 Booth digits covering the zero-extended
//          multiplier {2'b00, hid, frc} of MW+2 bits
//   ACC_W  accumulator width. This is the 2*MW product plus two guard bits, so
//          that negative partial products stay representable in two's
//          complement.
//   CNT_W  digit counter width, ceil(log2(ITER))
//   BW     multiplier window register width. This is MW+2 multiplier bits
//          plus the implicit B[-1] = 0 below bit 0.
// ----------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int MW    = 24;
    localparam int ITER  = (MW + 2) / 2;
    localparam int ACC_W = 2 * MW + 2;
    localparam int CNT_W = $clog2(ITER);
    localparam int BW    = MW + 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_st_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_dig_t;

    // Partial product for one Booth digit. The caller has already shifted the
    // multiplicand m into position.
    // The result is a two's-complement value at accumulator width, so the
    // negative digits sign-extend automatically.
    function automatic logic [ACC_W-1:0] booth_pp(input logic [ACC_W-1:0] m,
                                                  input booth_dig_t       dig);
        logic [ACC_W-1:0] pp;
        case (dig)
            P1:      pp = m;
            P2:      pp = m << 1;
            M1:      pp = -m;
            M2:      pp = -(m << 1);
            default: pp = '0;
        endcase
        return pp;
    endfunction

endpackage

// File: rtl/fp_booth_r4_enc.sv
// ----------------------------------------------------------------------------
// fp_booth_r4_enc
//   Combinational radix-4 Booth recoder. It maps the overlapping multiplier
//   window {B[2i+1], B[2i], B[2i-1]} onto one of the digits
//   {0, +1, +2, -1, -2}.
//
//   win  in   3  multiplier window, win[0] is the overlap bit B[2i-1]
//   dig  out  -  recoded Booth digit
// ----------------------------------------------------------------------------
module fp_booth_r4_enc
    import fp_mul_pkg::*;
(
    input  logic [2:0] win,
    output booth_dig_t dig
);

    // NOTE: a combinational block assigns its output a default first. A path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        dig = ZERO;
        case (win)
            3'b000:  dig = ZERO;
            3'b001:  dig = P1;
            3'b010:  dig = P1;
            3'b011:  dig = P2;
            3'b100:  dig = M2;
            3'b101:  dig = M1;
            3'b110:  dig = M1;
            3'b111:  dig = ZERO;
            default: dig = ZERO;
        endcase
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// ----------------------------------------------------------------------------
// fp_mul_booth_seq
//   Iterative radix-4 Booth significand multiplier for the FP multiply path.
//   It retires one Booth digit per cycle and produces the unsigned 2*MW-bit
//   product {hid_X,frc_X} * {hid_Y,frc_Y} for the normalisation stage.
//   Both sides use a valid/ready handshake. MW is taken from fp_mul_pkg.
//
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous reset, active-high
//   in_valid    in   1       operands valid
//   in_ready    out  1       operands accepted this cycle if in_valid
//   hid_X       in   1       hidden bit of X (0 for subnormal/zero)
//   frc_X       in   MW-1    fraction of X
//   hid_Y       in   1       hidden bit of Y
//   frc_Y       in   MW-1    fraction of Y
//   out_valid   out  1       frc_Z_full holds a finished product
//   out_ready   in   1       consumer accepts the product
//   frc_Z_full  out  2*MW    unsigned product
//   busy        out  1       iteration in progress
//
//   Parameter ZERO_BYPASS: when set, a zero significand on either side skips
//   the iteration. In that case the zero product is presented in the cycle
//   after the accept.
// ----------------------------------------------------------------------------
module fp_mul_booth_seq
    import fp_mul_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hid_X,
    input  logic [MW-2:0]    frc_X,
    input  logic             hid_Y,
    input  logic [MW-2:0]    frc_Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*MW-1:0]  frc_Z_full,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    mul_st_t          state_q;
    mul_st_t          state_d;

    logic [MW-1:0]    sig_x;
    logic [MW-1:0]    sig_y;
    logic             accept;
    logic             bypass;
    logic             last_digit;

    logic [ACC_W-1:0] m_q;      // multiplicand, pre-shifted by 2i
    logic [BW-1:0]    b_q;      // multiplier window, low 3 bits = current digit
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    booth_dig_t       dig;
    logic [ACC_W-1:0] pp;
    logic [ACC_W-1:0] acc_sum;

    assign sig_x      = {hid_X, frc_X};
    assign sig_y      = {hid_Y, frc_Y};
    assign bypass     = ZERO_BYPASS && ((sig_x == '0) || (sig_y == '0));
    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // Booth digit and partial product for the current CALC cycle
    // ------------------------------------------------------------------
    fp_booth_r4_enc u_enc (
        .win (b_q[2:0]),
        .dig (dig)
    );

    assign pp      = booth_pp(m_q, dig);
    assign acc_sum = acc_q + pp;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments. Every
    // register then samples its pre-edge value, and simulation matches the
    // synthesised flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = bypass ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // The result is leaving this cycle, so new operands can
                // land in the same cycle.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = bypass ? DONE : CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, accumulator, digit counter, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            frc_Z_full <= '0;
        end else if (accept) begin
            m_q   <= {{(ACC_W - MW){1'b0}}, sig_x};
            // Two zero-extension bits keep B unsigned. The trailing 0 is B[-1].
            b_q   <= {2'b00, sig_y, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
            if (bypass) begin
                frc_Z_full <= '0;
            end
        end else if (state_q == CALC) begin
            acc_q <= acc_sum;
            m_q   <= m_q << 2;
            b_q   <= b_q >> 2;
            if (last_digit) begin
                // The result register only changes on entry to DONE. It
                // therefore holds still under backpressure.
                frc_Z_full <= acc_sum[2*MW-1:0];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // The product of two MW-bit unsigned values fits in 2*MW bits. Any
    // leftover in the guard bits indicates a recoding or sign-extension bug.
    a_guard_bits_clear : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == DONE) |-> (acc_q[ACC_W-1:2*MW] == '0)
    );

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_booth_seq
//   Directed bench for the sequential Booth significand multiplier.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
//   Latency is counted as the number of rising edges after the accept edge
//   until out_valid is seen: 13 for an iterated product, and 0 for a bypass.
//   With a bypass, the result is valid in the cycle following the accept.
// ----------------------------------------------------------------------------
module tb_fp_mul_booth_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        hid_X;
    logic [22:0] frc_X;
    logic        hid_Y;
    logic [22:0] frc_Y;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] frc_Z_full;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam int MAX_WAIT = 40;

    always #5 clk = ~clk;

    fp_mul_booth_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hid_X      (hid_X),
        .frc_X      (frc_X),
        .hid_Y      (hid_Y),
        .frc_Y      (frc_Y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frc_Z_full (frc_Z_full),
        .busy       (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Golden product, computed directly with the * operator.
    function automatic logic [47:0] gold(input logic hx, input logic [22:0] fx,
                                         input logic hy, input logic [22:0] fy);
        logic [47:0] a;
        logic [47:0] b;
        a = {24'd0, hx, fx};
        b = {24'd0, hy, fy};
        return a * b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for exactly one accept edge. Afterwards, scramble
    // the inputs: the DUT must use only the captured values.
    task automatic launch(input logic hx, input logic [22:0] fx,
                          input logic hy, input logic [22:0] fy);
        hid_X    = hx;
        frc_X    = fx;
        hid_Y    = hy;
        frc_Y    = fy;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        hid_X    = ~hx;
        frc_X    = ~fx;
        hid_Y    = ~hy;
        frc_Y    = ~fy;
    endtask

    task automatic wait_valid(output int edges, output bit timed_out);
        edges     = 0;
        timed_out = 1'b0;
        while (!out_valid) begin
            if (edges >= MAX_WAIT) begin
                timed_out = 1'b1;
                return;
            end
            tick();
            edges++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Launch one product, wait for it, and check its latency and value.
    task automatic run_and_check(input string name,
                                 input logic hx, input logic [22:0] fx,
                                 input logic hy, input logic [22:0] fy,
                                 input logic [47:0] exp, input int exp_lat);
        int edges;
        bit to;
        launch(hx, fx, hy, fy);
        wait_valid(edges, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, MAX_WAIT);
        end
        checks++;
        if (edges !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, edges, exp_lat);
        end
        checks++;
        if (frc_Z_full !== exp) begin
            errors++;
            $display("FAIL %s product: got %h expected %h", name, frc_Z_full, exp);
        end
        retire();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hid_X = 1'b0; frc_X = '0; hid_Y = 1'b0; frc_Y = '0;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset busy: got %b expected 0", busy);
        end
        checks++;
        if (frc_Z_full !== 48'h0) begin
            errors++; $display("FAIL reset frc_Z_full: got %h expected 0", frc_Z_full);
        end
    endtask

    task automatic test_one_times_one();
        int edges;
        bit to;
        launch(1'b1, 23'h0, 1'b1, 23'h0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL one_calc_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0",
                     busy, in_ready);
        end
        wait_valid(edges, to);
        checks++;
        if (to || edges !== 13) begin
            errors++; $display("FAIL one latency: got %0d (timeout=%0b) expected 13", edges, to);
        end
        checks++;
        if (frc_Z_full !== 48'h4000_0000_0000) begin
            errors++; $display("FAIL one product: got %h expected 400000000000", frc_Z_full);
        end
        retire();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_retire: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_max_times_max();
        run_and_check("max", 1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 48'hFFFF_FE00_0001, 13);
    endtask

    task automatic test_e_pi();
        run_and_check("e_pi", 1'b1, 23'h2DF854, 1'b1, 23'h490FDB,
                      gold(1'b1, 23'h2DF854, 1'b1, 23'h490FDB), 13);
        run_and_check("subnormal", 1'b0, 23'h2DF854, 1'b1, 23'h490FDB,
                      gold(1'b0, 23'h2DF854, 1'b1, 23'h490FDB), 13);
        // 1.5 * (1 + 2^-23): 0xC00000 * 0x800001
        run_and_check("one_half", 1'b1, 23'h400000, 1'b1, 23'h000001,
                      48'h6000_00C0_0000, 13);
    endtask

    task automatic test_zero_bypass();
        // The previous result is non-zero, so a zero here must come from the bypass.
        run_and_check("max_before_bypass", 1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF,
                      48'hFFFF_FE00_0001, 13);
        run_and_check("bypass_x", 1'b0, 23'h0, 1'b1, 23'h123456, 48'h0, 0);
        run_and_check("bypass_y", 1'b1, 23'h7FFFFF, 1'b0, 23'h0, 48'h0, 0);
    endtask

    task automatic test_busy_ignore();
        int edges;
        bit to;
        launch(1'b1, 23'h400000, 1'b1, 23'h000001);
        repeat (2) tick();
        hid_X = 1'b1; frc_X = 23'h7FFFFF; hid_Y = 1'b1; frc_Y = 23'h7FFFFF;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL busy_in_ready: got %b expected 0", in_ready);
        end
        repeat (3) tick();
        in_valid = 1'b0;
        wait_valid(edges, to);
        checks++;
        if (to || edges !== 8) begin
            errors++; $display("FAIL busy_latency: got %0d (timeout=%0b) expected 8", edges, to);
        end
        checks++;
        if (frc_Z_full !== 48'h6000_00C0_0000) begin
            errors++; $display("FAIL busy_product: got %h expected 600000c00000", frc_Z_full);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int edges;
        bit to;
        logic [47:0] exp_ep;
        exp_ep = gold(1'b1, 23'h2DF854, 1'b1, 23'h490FDB);
        out_ready = 1'b0;
        launch(1'b1, 23'h2DF854, 1'b1, 23'h490FDB);
        wait_valid(edges, to);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || frc_Z_full !== exp_ep) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%b z=%h expected valid=1 z=%h",
                         i, out_valid, frc_Z_full, exp_ep);
            end
        end
        hid_X = 1'b1; frc_X = 23'h7FFFFF; hid_Y = 1'b1; frc_Y = 23'h7FFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_calc: got busy=%b out_valid=%b expected 1/0", busy, out_valid);
        end
        wait_valid(edges, to);
        checks++;
        if (to || edges !== 13) begin
            errors++; $display("FAIL b2b latency: got %0d (timeout=%0b) expected 13", edges, to);
        end
        checks++;
        if (frc_Z_full !== 48'hFFFF_FE00_0001) begin
            errors++; $display("FAIL b2b product: got %h expected fffffe000001", frc_Z_full);
        end
        retire();
    endtask

    task automatic test_reset_abort();
        int seen;
        launch(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || frc_Z_full !== 48'h0) begin
            errors++;
            $display("FAIL abort_calc: got in_ready=%b busy=%b out_valid=%b z=%h expected 1/0/0/0",
                     in_ready, busy, out_valid, frc_Z_full);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen);
        end
        // Abort while a result is being held in DONE.
        launch(1'b0, 23'h0, 1'b1, 23'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: got out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int edges;
        bit to;
        logic        hx;
        logic        hy;
        logic [22:0] fx;
        logic [22:0] fy;
        logic [47:0] exp;
        for (int n = 0; n < 8; n++) begin
            hx  = ($urandom_range(0, 3) != 0);
            hy  = ($urandom_range(0, 3) != 0);
            fx  = 23'($urandom);
            fy  = 23'($urandom);
            exp = gold(hx, fx, hy, fy);
            launch(hx, fx, hy, fy);
            wait_valid(edges, to);
            checks++;
            if (to || frc_Z_full !== exp) begin
                errors++;
                $display("FAIL random %0d: got %h (timeout=%0b) expected %h for X=%b_%h Y=%b_%h",
                         n, frc_Z_full, to, exp, hx, fx, hy, fy);
            end
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                tick();
                checks++;
                if (out_valid !== 1'b1 || frc_Z_full !== exp) begin
                    errors++;
                    $display("FAIL random_hold %0d: got valid=%b z=%h expected valid=1 z=%h",
                             n, out_valid, frc_Z_full, exp);
                end
            end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_one_times_one();
        test_max_times_max();
        test_e_pi();
        test_zero_bypass();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
